run_ctrl: RTL and testbench

- Core-side responder for the Start/Ack launch handshake that the top-level testbench drives on TopLevel.
- Sits inside TopLevel between the Start/Ack pins and the program counter / core enable.
- On a Start pulse it loads the PC with the base address of the current program, enables execution, and counts cycles.
- On Halt from the decoder, or on watchdog timeout, it stops the core, raises Ack and advances to the next program (P1 -> P2 -> P3 -> P1).

---
 rtl/run_ctrl_pkg.sv | 38 +++
 rtl/run_ctrl_if.sv | 46 ++++
 rtl/sat_counter.sv | 48 ++++
 rtl/run_ctrl.sv | 134 +++++++++++++
 tb/tb_run_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and helpers for the Start/Ack launch controller.
//   state_e        : controller states (IDLE, ARMED, RUN, DONE)
//   NUM_PROGS_MAX  : largest program table the ProgIdx field can address
//   IDX_W          : width of ProgIdx
//   prog_base()    : maps a program index to its PC start address
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_PROGS_MAX = 4;
  localparam int IDX_W         = $clog2(NUM_PROGS_MAX);

  // Base address lookup. Indices beyond the table fall back to program 0,
  // which is also where the launch sequence wraps to.
  function automatic int unsigned prog_base(
    input logic [IDX_W-1:0] idx,
    input int unsigned      base0,
    input int unsigned      base1,
    input int unsigned      base2
  );
    int unsigned r;
    case (idx)
      2'd1:    r = base1;
      2'd2:    r = base2;
      default: r = base0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// -----------------------------------------------------------------------------
// run_ctrl_if
// Signal bundle between the launch bench / decoder and run_ctrl.
//   Start     : launch request (level)           bench   -> ctrl
//   Halt      : halt decode, only used in RUN    decoder -> ctrl
//   Ack       : program finished, held until next accepted Start
//   Run       : core enable
//   PcLoad    : PC load strobe, PcLoadVal is the address to load
//   ProgIdx   : current/next program index
//   CycleCnt  : RUN cycles of last/current program (saturating)
//   Timeout   : last program was stopped by the watchdog
//   DbgState  : controller state, for checkers
//
// Handshake: a launch is accepted on any rising Clk edge where Start=1 and the
// controller is IDLE or DONE; Ack drops on that same edge. Start must then fall
// before the program runs; the run completes with Ack=1, which stays high until
// the next accepted Start. Start seen while running is ignored.
// -----------------------------------------------------------------------------
interface run_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) ();
  import run_ctrl_pkg::*;

  logic                 Start;
  logic                 Halt;
  logic                 Ack;
  logic                 Run;
  logic                 PcLoad;
  logic [PC_W-1:0]      PcLoadVal;
  logic [IDX_W-1:0]     ProgIdx;
  logic [CNT_W-1:0]     CycleCnt;
  logic                 Timeout;
  state_e               DbgState;

  modport slave (
    input  Start, Halt,
    output Ack, Run, PcLoad, PcLoadVal, ProgIdx, CycleCnt, Timeout, DbgState
  );

  modport master (
    output Start, Halt,
    input  Ack, Run, PcLoad, PcLoadVal, ProgIdx, CycleCnt, Timeout, DbgState
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear, count enable, saturation at all-ones and a
// terminal-count flag comparing the current value against a limit.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear to zero
//   en_i    : count enable
//   limit_i : terminal-count compare value
//   cnt_o   : current count
//   tc_o    : cnt_o == limit_i
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Core-side responder for the Start/Ack launch handshake. A Start pulse arms
// the controller, which holds the PC at the current program's base address
// while Start stays high; when Start falls the core runs until Halt or the
// watchdog fires, then Ack is raised and the next program is selected
// (P1 -> P2 -> P3 -> P1).
//   Clk   : clock, all state changes on the rising edge
//   Reset : synchronous active-high reset, overrides everything
//   bus   : run_ctrl_if slave modport (Start/Halt in; Ack, Run, PcLoad,
//           PcLoadVal, ProgIdx, CycleCnt, Timeout, DbgState out)
// -----------------------------------------------------------------------------
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int NUM_PROGS  = 3,
  parameter int PROG_BASE0 = 0,
  parameter int PROG_BASE1 = 128,
  parameter int PROG_BASE2 = 256,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50000
) (
  input  logic         Clk,
  input  logic         Reset,
  run_ctrl_if.slave    bus
);

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              run_q, run_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_next;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_tc;

  // The watchdog fires while the counter still shows MAX_CYCLES-1, so the
  // final RUN cycle is counted and CycleCnt reads MAX_CYCLES afterwards.
  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (CNT_W'(MAX_CYCLES - 1)),
    .cnt_o   (cnt),
    .tc_o    (cnt_tc)
  );

  assign idx_next = (idx_q == IDX_W'(NUM_PROGS - 1)) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    idx_d     = idx_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          state_d   = ST_ARMED;
          ack_d     = 1'b0;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end

      ST_ARMED: begin
        if (!bus.Start) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
      end

      ST_RUN: begin
        cnt_en = 1'b1;
        // Halt takes precedence over a watchdog expiry in the same cycle.
        if (bus.Halt) begin
          state_d   = ST_DONE;
          run_d     = 1'b0;
          ack_d     = 1'b1;
          timeout_d = 1'b0;
          idx_d     = idx_next;
        end else if (cnt_tc) begin
          state_d   = ST_DONE;
          run_d     = 1'b0;
          ack_d     = 1'b1;
          timeout_d = 1'b1;
          idx_d     = idx_next;
        end
      end

      default: begin
        state_d = ST_IDLE;
        run_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      run_q     <= 1'b0;
      timeout_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.Ack       = ack_q;
  assign bus.Run       = run_q;
  assign bus.Timeout   = timeout_q;
  assign bus.ProgIdx   = idx_q;
  assign bus.CycleCnt  = cnt;
  assign bus.DbgState  = state_q;
  // PcLoad is decoded so the PC sees the load strobe in every ARMED cycle.
  assign bus.PcLoad    = (state_q == ST_ARMED);
  assign bus.PcLoadVal = PC_W'(prog_base(idx_q, PROG_BASE0, PROG_BASE1, PROG_BASE2));

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
// Self-checking bench for run_ctrl. Each launch is described by how long Start
// is held, on which RUN cycle Halt is raised (0 = never), and optional Start
// poke / Reset points inside RUN. Expected outcomes come from a launch-level
// model: program index rotation, base table, and min(halt, watchdog) length.
// -----------------------------------------------------------------------------
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int TB_PC_W  = 10;
  localparam int TB_CNT_W = 16;
  localparam int TB_MAX   = 24;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  int base_tab[3] = '{0, 128, 256};
  int model_idx = 0;
  logic [TB_CNT_W-1:0] exp_q[$];

  run_ctrl_if #(.PC_W(TB_PC_W), .CNT_W(TB_CNT_W)) bus ();

  run_ctrl #(
    .PC_W       (TB_PC_W),
    .NUM_PROGS  (3),
    .PROG_BASE0 (0),
    .PROG_BASE1 (128),
    .PROG_BASE2 (256),
    .CNT_W      (TB_CNT_W),
    .MAX_CYCLES (TB_MAX)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ack",    int'(bus.Ack), 0);
      chk("idle_run",    int'(bus.Run), 0);
      chk("idle_pcload", int'(bus.PcLoad), 0);
      chk("idle_idx",    int'(bus.ProgIdx), 0);
      chk("idle_cnt",    int'(bus.CycleCnt), 0);
      chk("idle_to",     int'(bus.Timeout), 0);
      bus.Halt = 1'($urandom_range(0, 1));
    end
    bus.Halt = 1'b0;
  endtask

  // DONE dwell: outputs frozen, Halt noise must be ignored.
  task automatic done_dwell(input int n, input int exp_cnt, input int exp_to);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("done_ack",    int'(bus.Ack), 1);
      chk("done_run",    int'(bus.Run), 0);
      chk("done_pcload", int'(bus.PcLoad), 0);
      chk("done_cnt",    int'(bus.CycleCnt), exp_cnt);
      chk("done_to",     int'(bus.Timeout), exp_to);
      chk("done_idx",    int'(bus.ProgIdx), model_idx);
      bus.Halt = 1'($urandom_range(0, 1));
    end
    bus.Halt = 1'b0;
  endtask

  // Always entered and left just after a falling edge.
  task automatic launch(input int s_cycles, input int halt_at,
                        input int poke_at, input int rst_at);
    int base;
    int c_end;
    int exp_to;
    base   = base_tab[model_idx];
    exp_to = (halt_at == 0 || halt_at > TB_MAX) ? 1 : 0;
    c_end  = (exp_to == 1) ? TB_MAX : halt_at;

    bus.Start = 1'b1;
    for (int k = 0; k < s_cycles; k++) begin
      @(negedge clk);
      chk("armed_pcload", int'(bus.PcLoad), 1);
      chk("armed_pcval",  int'(bus.PcLoadVal), base);
      chk("armed_run",    int'(bus.Run), 0);
      chk("armed_ack",    int'(bus.Ack), 0);
      chk("armed_to",     int'(bus.Timeout), 0);
      chk("armed_cnt",    int'(bus.CycleCnt), 0);
      chk("armed_idx",    int'(bus.ProgIdx), model_idx);
      bus.Halt = 1'($urandom_range(0, 1));
      if (k == s_cycles - 1) bus.Start = 1'b0;
    end

    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      chk("run_run",    int'(bus.Run), 1);
      chk("run_pcload", int'(bus.PcLoad), 0);
      chk("run_cnt",    int'(bus.CycleCnt), c - 1);
      chk("run_idx",    int'(bus.ProgIdx), model_idx);
      chk("run_ack",    int'(bus.Ack), 0);
      bus.Start = (c == poke_at);
      bus.Halt  = (c == halt_at);
      if (c == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Halt  = 1'b0;
        chk("rst_run",    int'(bus.Run), 0);
        chk("rst_ack",    int'(bus.Ack), 0);
        chk("rst_idx",    int'(bus.ProgIdx), 0);
        chk("rst_cnt",    int'(bus.CycleCnt), 0);
        chk("rst_pcload", int'(bus.PcLoad), 0);
        @(negedge clk);
        reset = 1'b0;
        model_idx = 0;
        return;
      end
    end

    @(negedge clk);
    bus.Start = 1'b0;
    bus.Halt  = 1'b0;
    model_idx = (model_idx + 1) % 3;
    exp_q.push_back(TB_CNT_W'(c_end));
    chk("end_run",    int'(bus.Run), 0);
    chk("end_ack",    int'(bus.Ack), 1);
    chk("end_to",     int'(bus.Timeout), exp_to);
    chk("end_idx",    int'(bus.ProgIdx), model_idx);
    chk("end_pcload", int'(bus.PcLoad), 0);
    chk("end_cnt",    int'(bus.CycleCnt), int'(exp_q.pop_front()));
    done_dwell($urandom_range(1, 3), c_end, exp_to);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int s;
    int h;
    int ce;
    int p;

    bus.Start = 1'b0;
    bus.Halt  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_check(5);

    launch(1, 20, 0, 0);                          // P1, halt on 20th cycle
    launch(3, 7, 0, 0);                           // P2, Start held 3 cycles
    launch(2, $urandom_range(1, TB_MAX), 0, 0);   // P3
    launch(1, 5, 0, 0);                           // wrap back to P1
    launch(2, 0, 0, 0);                           // watchdog timeout
    launch(1, TB_MAX, 0, 0);                      // halt ties with watchdog
    launch(1, 30, 3, 5);                          // Start poke, reset at cycle 5
    idle_check(3);
    launch(1, 4, 2, 0);                           // after reset loads base 0

    for (int i = 0; i < 10; i++) begin
      s  = $urandom_range(1, 4);
      h  = $urandom_range(0, TB_MAX + 4);
      ce = (h == 0 || h > TB_MAX) ? TB_MAX : h;
      p  = (ce > 2) ? $urandom_range(0, ce - 1) : 0;
      launch(s, h, p, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
